// File: rtl/fft_round_sched_pkg.sv
// Shared definitions for the radix-2 FFT round scheduler: state encodings and width helpers.

package fft_round_sched_pkg;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;
   localparam logic [1:0] StFin   = 2'd3;

   // Degenerate zero-width counters are widened to one bit that simply stays at zero.
   function automatic int unsigned at_least_one(input int unsigned w);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/fft_round_sched_addr_gen.sv
// Combinational butterfly address generator: (round, butterfly index) -> a/b addresses
// and twiddle index for one lane of the in-place radix-2 FFT.

module fft_round_sched_addr_gen #(
   parameter int unsigned LOGN = 12
) (
   input  logic [LOGN-1:0] rnd_i,
   input  logic [LOGN-2:0] b_i,
   output logic [LOGN-1:0] addra_o,
   output logic [LOGN-1:0] addrb_o,
   output logic [LOGN-2:0] tw_o
);

   localparam logic [LOGN-1:0] One = LOGN'(1);

   logic [LOGN-1:0] b_ext;
   logic [LOGN-1:0] half;
   logic [LOGN-1:0] grp;
   logic [LOGN-1:0] pos;
   logic [LOGN-1:0] addra;
   logic [LOGN-1:0] tw_sh;

   always_comb begin
      b_ext   = {1'b0, b_i};
      half    = One << rnd_i;
      grp     = b_ext >> rnd_i;
      pos     = b_ext & (half - One);
      // Group base sits at a stride of 2*half; pos indexes within the lower half.
      addra   = (grp << (rnd_i + One)) | pos;
      tw_sh   = LOGN'(LOGN - 1) - rnd_i;
      addra_o = addra;
      addrb_o = addra + half;
      tw_o    = (LOGN-1)'(pos << tw_sh);
   end

endmodule

// File: rtl/fft_round_sched.sv
// In-place radix-2 FFT round scheduler: issues P butterflies per cycle over LOGN rounds,
// drains the op-unit pipeline between rounds and delays reads into write-back addresses.

module fft_round_sched
   import fft_round_sched_pkg::*;
#(
   parameter int unsigned LOGN = 12,
   parameter int unsigned LOGP = 1,
   parameter int unsigned LAT  = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              sig,
   output logic                              busy,
   output logic                              done,
   output logic [LOGN-1:0]                   rnd,
   output logic                              rd_valid,
   output logic [(1<<LOGP)*LOGN-1:0]         rd_addra,
   output logic [(1<<LOGP)*LOGN-1:0]         rd_addrb,
   output logic [(1<<LOGP)*(LOGN-1)-1:0]     tw_idx,
   output logic                              wb_valid,
   output logic [(1<<LOGP)*LOGN-1:0]         wb_addra,
   output logic [(1<<LOGP)*LOGN-1:0]         wb_addrb
);

   localparam int unsigned P        = 1 << LOGP;
   localparam int unsigned AW       = P * LOGN;
   localparam int unsigned TW       = P * (LOGN - 1);
   localparam int unsigned IterBits = LOGN - 1 - LOGP;
   localparam int unsigned IterW    = at_least_one(IterBits);
   localparam int unsigned CntW     = at_least_one($clog2(LAT));

   localparam logic [IterW-1:0] IterLast = IterW'((1 << IterBits) - 1);
   localparam logic [CntW-1:0]  CntLast  = CntW'(LAT - 1);
   localparam logic [LOGN-1:0]  RndLast  = LOGN'(LOGN - 1);

   logic [1:0]       state_q, state_d;
   logic [IterW-1:0] iter_q, iter_d;
   logic [LOGN-1:0]  rnd_q, rnd_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic             rd_valid_q, rd_valid_d;
   logic [AW-1:0]    rd_addra_q, rd_addra_d;
   logic [AW-1:0]    rd_addrb_q, rd_addrb_d;
   logic [TW-1:0]    tw_idx_q, tw_idx_d;

   logic [AW-1:0]    gen_a;
   logic [AW-1:0]    gen_b;
   logic [TW-1:0]    gen_tw;

   logic [LAT-1:0]         dly_valid_q, dly_valid_d;
   logic [LAT-1:0][AW-1:0] dly_a_q, dly_a_d;
   logic [LAT-1:0][AW-1:0] dly_b_q, dly_b_d;

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      rnd_d   = rnd_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (sig) begin
               state_d = StRun;
               iter_d  = '0;
               rnd_d   = '0;
            end
         end
         StRun: begin
            if (iter_q == IterLast) begin
               state_d = StDrain;
               iter_d  = '0;
               cnt_d   = '0;
            end else begin
               iter_d = iter_q + IterW'(1);
            end
         end
         StDrain: begin
            // Hold off the next round until the last write-back of this one has landed.
            if (cnt_q == CntLast) begin
               if (rnd_q == RndLast) begin
                  state_d = StFin;
               end else begin
                  state_d = StRun;
                  rnd_d   = rnd_q + LOGN'(1);
                  iter_d  = '0;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StFin: begin
            state_d = StIdle;
            rnd_d   = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   // Addresses are generated from next-state so the registered rd_* line up with rd_valid.
   for (genvar j = 0; j < P; j++) begin : g_lane
      logic [LOGN-2:0] lane_b;
      assign lane_b = ((LOGN-1)'(iter_d) << LOGP) | (LOGN-1)'(j);

      fft_round_sched_addr_gen #(
         .LOGN(LOGN)
      ) u_addr_gen (
         .rnd_i   (rnd_d),
         .b_i     (lane_b),
         .addra_o (gen_a[j*LOGN +: LOGN]),
         .addrb_o (gen_b[j*LOGN +: LOGN]),
         .tw_o    (gen_tw[j*(LOGN-1) +: (LOGN-1)])
      );
   end

   always_comb begin
      rd_valid_d = (state_d == StRun);
      rd_addra_d = rd_valid_d ? gen_a  : rd_addra_q;
      rd_addrb_d = rd_valid_d ? gen_b  : rd_addrb_q;
      tw_idx_d   = rd_valid_d ? gen_tw : tw_idx_q;
   end

   always_comb begin
      dly_valid_d    = dly_valid_q;
      dly_a_d        = dly_a_q;
      dly_b_d        = dly_b_q;
      dly_valid_d[0] = rd_valid_q;
      dly_a_d[0]     = rd_addra_q;
      dly_b_d[0]     = rd_addrb_q;
      for (int k = 1; k < LAT; k++) begin
         dly_valid_d[k] = dly_valid_q[k-1];
         dly_a_d[k]     = dly_a_q[k-1];
         dly_b_d[k]     = dly_b_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         iter_q      <= '0;
         rnd_q       <= '0;
         cnt_q       <= '0;
         rd_valid_q  <= 1'b0;
         rd_addra_q  <= '0;
         rd_addrb_q  <= '0;
         tw_idx_q    <= '0;
         dly_valid_q <= '0;
         dly_a_q     <= '0;
         dly_b_q     <= '0;
      end else begin
         state_q     <= state_d;
         iter_q      <= iter_d;
         rnd_q       <= rnd_d;
         cnt_q       <= cnt_d;
         rd_valid_q  <= rd_valid_d;
         rd_addra_q  <= rd_addra_d;
         rd_addrb_q  <= rd_addrb_d;
         tw_idx_q    <= tw_idx_d;
         dly_valid_q <= dly_valid_d;
         dly_a_q     <= dly_a_d;
         dly_b_q     <= dly_b_d;
      end
   end

   assign busy     = (state_q == StRun) || (state_q == StDrain);
   assign done     = (state_q == StFin);
   assign rnd      = rnd_q;
   assign rd_valid = rd_valid_q;
   assign rd_addra = rd_addra_q;
   assign rd_addrb = rd_addrb_q;
   assign tw_idx   = tw_idx_q;
   assign wb_valid = dly_valid_q[LAT-1];
   assign wb_addra = dly_a_q[LAT-1];
   assign wb_addrb = dly_b_q[LAT-1];

endmodule

// File: tb/tb_fft_round_sched.sv
// Scoreboard bench for fft_round_sched at LOGN=4, LOGP=1, LAT=3: expected read and
// write-back beats are queued at start, a negedge monitor pops and compares them.

module tb_fft_round_sched;

   localparam int LOGN = 4;
   localparam int LOGP = 1;
   localparam int LAT  = 3;
   localparam int P    = 2;
   localparam int N    = 16;

   logic       clk;
   logic       rst;
   logic       sig;
   logic       busy;
   logic       done;
   logic [3:0] rnd;
   logic       rd_valid;
   logic [7:0] rd_addra;
   logic [7:0] rd_addrb;
   logic [5:0] tw_idx;
   logic       wb_valid;
   logic [7:0] wb_addra;
   logic [7:0] wb_addrb;

   fft_round_sched #(
      .LOGN(LOGN),
      .LOGP(LOGP),
      .LAT (LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sig      (sig),
      .busy     (busy),
      .done     (done),
      .rnd      (rnd),
      .rd_valid (rd_valid),
      .rd_addra (rd_addra),
      .rd_addrb (rd_addrb),
      .tw_idx   (tw_idx),
      .wb_valid (wb_valid),
      .wb_addra (wb_addra),
      .wb_addrb (wb_addrb)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [5:0] tw;
      int         r;
   } item_t;

   item_t rd_q[$];
   item_t wb_q[$];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int exp_done = -1;
   int done_cnt, rd_cnt, wb_cnt, busy_cnt, dup_cnt;
   logic [15:0] mask [4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int any_out();
      return (busy || done || rd_valid || wb_valid || (rnd != 0) || (rd_addra != 0) ||
              (rd_addrb != 0) || (tw_idx != 0) || (wb_addra != 0) || (wb_addrb != 0)) ? 1 : 0;
   endfunction

   // Monitor
   item_t it;
   int    ra, rb, ri;
   logic [15:0] bits;
   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (done) begin
         done_cnt++;
         check("done_cycle", cyc, exp_done);
      end
      if (rd_valid) begin
         rd_cnt++;
         if (rd_q.size() == 0) begin
            check("rd_unexpected", 1, 0);
         end else begin
            it = rd_q.pop_front();
            check("rd_rnd", int'(rnd), it.r);
            check("rd_addra", int'(rd_addra), int'(it.a));
            check("rd_addrb", int'(rd_addrb), int'(it.b));
            check("rd_tw", int'(tw_idx), int'(it.tw));
         end
         ri = int'(rnd);
         if (ri < 4) begin
            for (int j = 0; j < P; j++) begin
               ra   = int'(rd_addra[j*4 +: 4]);
               rb   = int'(rd_addrb[j*4 +: 4]);
               bits = (16'd1 << ra) | (16'd1 << rb);
               if ((mask[ri] & bits) != 16'd0) dup_cnt++;
               mask[ri] = mask[ri] | bits;
            end
         end
      end
      if (wb_valid) begin
         wb_cnt++;
         if (wb_q.size() == 0) begin
            check("wb_unexpected", 1, 0);
         end else begin
            it = wb_q.pop_front();
            check("wb_addra", int'(wb_addra), int'(it.a));
            check("wb_addrb", int'(wb_addrb), int'(it.b));
         end
      end
   end

   task automatic to_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic clear_stats();
      done_cnt = 0;
      rd_cnt   = 0;
      wb_cnt   = 0;
      busy_cnt = 0;
      dup_cnt  = 0;
      for (int r = 0; r < 4; r++) mask[r] = '0;
   endtask

   // Butterflies enumerated group by group; P consecutive ones form one issue beat.
   task automatic push_model();
      int    a_l[8];
      int    b_l[8];
      int    t_l[8];
      int    half;
      int    k;
      item_t e;
      for (int r = 0; r < LOGN; r++) begin
         half = 1 << r;
         for (int g = 0; g < (N >> (r + 1)); g++) begin
            for (int p = 0; p < half; p++) begin
               k      = g * half + p;
               a_l[k] = g * 2 * half + p;
               b_l[k] = a_l[k] + half;
               t_l[k] = p * (N / 2) / half;
            end
         end
         for (int i = 0; i < 4; i++) begin
            e.a  = 8'((a_l[2*i+1] << 4) | a_l[2*i]);
            e.b  = 8'((b_l[2*i+1] << 4) | b_l[2*i]);
            e.tw = 6'((t_l[2*i+1] << 3) | t_l[2*i]);
            e.r  = r;
            rd_q.push_back(e);
            wb_q.push_back(e);
         end
      end
   endtask

   task automatic start_run(output int t0);
      clear_stats();
      push_model();
      t0       = cyc;
      exp_done = cyc + 1 + LOGN * (N / (2 * P) + LAT);
      sig      = 1'b1;
      @(negedge clk);
      sig      = 1'b0;
   endtask

   task automatic finish_run(input int t0);
      while (done_cnt == 0 && cyc < t0 + 60) @(negedge clk);
      @(negedge clk);
      check("done_count", done_cnt, 1);
      check("busy_cycles", busy_cnt, 28);
      check("rd_beats", rd_cnt, 16);
      check("wb_beats", wb_cnt, 16);
      check("rd_left", rd_q.size(), 0);
      check("wb_left", wb_q.size(), 0);
      check("dup_reads", dup_cnt, 0);
      for (int r = 0; r < 4; r++) check("round_cover", int'(mask[r]), 16'hFFFF);
   endtask

   int t0, t1, t2;
   initial begin
      clear_stats();
      rst = 1'b0;
      sig = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outs", any_out(), 0);
      rst = 1'b1;
      sig = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_after_reset", any_out(), 0);

      // Full run with a stray start pulse mid-transform
      start_run(t0);
      check("r0i0_valid", int'(rd_valid), 1);
      check("r0i0_busy", int'(busy), 1);
      check("r0i0_addra", int'(rd_addra), 8'h20);
      check("r0i0_addrb", int'(rd_addrb), 8'h31);
      check("r0i0_tw", int'(tw_idx), 0);
      to_cyc(t0 + 12);
      sig = 1'b1;
      @(negedge clk);
      sig = 1'b0;
      to_cyc(t0 + 16);
      check("r2i1_rnd", int'(rnd), 2);
      check("r2i1_addra", int'(rd_addra), 8'h32);
      check("r2i1_addrb", int'(rd_addrb), 8'h76);
      check("r2i1_tw", int'(tw_idx), 6'h34);
      to_cyc(t0 + 19);
      check("r2i1_wb_valid", int'(wb_valid), 1);
      check("r2i1_wb_addra", int'(wb_addra), 8'h32);
      check("r2i1_wb_addrb", int'(wb_addrb), 8'h76);
      to_cyc(t0 + 28);
      check("last_busy", int'(busy), 1);
      to_cyc(t0 + 29);
      check("fin_busy", int'(busy), 0);
      finish_run(t0);
      check("idle_rnd", int'(rnd), 0);

      // Reset during round 1 discards everything in flight
      start_run(t1);
      to_cyc(t1 + 10);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("midrst_outs", any_out(), 0);
      exp_done = -1;
      rd_q.delete();
      wb_q.delete();
      to_cyc(t1 + 50);
      check("midrst_no_done", done_cnt, 0);

      // Fresh transform after the abort
      start_run(t2);
      finish_run(t2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
